seq_alu_unit: RTL and testbench
===============================

// Module: seq_alu_unit
// PURPOSE
//  Registered, handshaked successor to the combinational datapath ALU.
//  Width is parametrised, and an iterative unsigned multiply op is added.
//  Operands are accepted on a valid/ready input channel; results and flags are
//  returned on a valid/ready output channel.
//  Sits between the decode/issue stage and writeback; it stalls issue during
//  a multiply.
// PARAMETERS
//  N    32            datapath width (>=4)
//  SHW  $clog2(N)     shift-amount width
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    reset, asynchronous assert, active-low
//  in_valid   in   1    operand beat valid
//  in_ready   out  1    unit can accept an operand beat
//  opcode     in   3    operation select (table below)
//  in1        in   N    operand A
//  in2        in   N    operand B
//  shamt      in   SHW  shift amount
//  out_valid  out  1    result beat valid
//  out_ready  in   1    consumer accepts result
//  result     out  N    registered result
//  overflow   out  1    add/sub: signed overflow; mul: product high half != 0; else 0
//  zero       out  1    result == 0
//  sign       out  1    result[N-1]
// BEHAVIOUR
//  Opcodes:
//   000 add
//   001 sub (in1-in2)
//   010 srl in1>>shamt
//   011 sll in1<<shamt
//   100 ~(in1&in2)
//   101 slt signed (result = 1 or 0)
//   110 min signed
//   111 mul unsigned (result = low N bits)
//  FSM states IDLE, MUL, DONE:
//   IDLE: in_ready=1. On in_valid, capture operands.
//    Opcode != 111 -> compute and register -> DONE.
//    Opcode == 111 -> MUL, counter=0, acc=0.
//   MUL: in_ready=0. One shift-add step per cycle over 2N-bit acc.
//    Leave for DONE after exactly N steps.
//   DONE: out_valid=1. result/flags held stable until out_ready.
//    out_ready=1 and in_valid=0 -> IDLE.
//  Back-to-back: in_ready = IDLE | (DONE & out_ready).
//   If both handshakes fire in DONE, the new op is captured that edge with no
//   bubble (non-mul -> DONE again, mul -> MUL).
//  Latency (accept edge T):
//   non-mul -> out_valid at T+1
//   mul     -> out_valid at T+N+1
//  Inputs are ignored when in_ready=0. Operands are sampled only at accept.
//  Arithmetic:
//   add/sub are modulo 2^N. overflow = operand signs agree (B inverted for
//   sub) and differ from the result sign.
//   shamt >= N is impossible by width.
//   zero and sign are derived from the registered result for every opcode.
//  Reset (any state, including mid-multiply):
//   state=IDLE, out_valid=0, result=0, overflow=0, zero=1, sign=0.
//   Counter and acc are cleared and any in-flight op is discarded.
//   in_ready=1 after reset deasserts.
//  out_valid never drops without out_ready (no retraction).
// TESTING (N=32)
//  1 add 0x7FFFFFFF+1, out_ready=1
//    -> out_valid at T+1; result 0x80000000, overflow=1, sign=1, zero=0
//  2 sub 5-5, then slt -1<1, back-to-back with out_ready=1
//    -> results 0 (zero=1), then 1 on consecutive cycles; no bubble
//  3 mul 0x00010000*0x00010000
//    -> in_ready=0 for 32 cycles; result 0, overflow=1, zero=1 at T+33
//  4 mul 123*456 with out_ready=0 for 5 cycles after out_valid
//    -> result 56088 held stable; in_ready=0 until out_ready
//  5 rst_n pulsed low at step 10 of a mul
//    -> immediately out_valid=0, result=0, zero=1; next op accepted normally
//  6 min(-3,2), sll 1<<31, nand 0xFFFFFFFF,0xFFFFFFFF
//    -> 0xFFFFFFFD, 0x80000000, 0x00000000 (zero=1)

Source files
------------

// File: rtl/seq_alu_unit_if.sv
// Purpose  : operand/result channel bundle for seq_alu_unit (issue side = master, ALU = slave).
// Latency  : none, wires only.
// Backpress: valid/ready on both channels; a beat moves when valid and ready are both high.
// Signals  : in_valid/in_ready/opcode/in1/in2/shamt form the operand channel,
//            out_valid/out_ready/result/overflow/zero/sign form the result channel.
interface seq_alu_unit_if #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
);
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     opcode;
    logic [N-1:0]   in1;
    logic [N-1:0]   in2;
    logic [SHW-1:0] shamt;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   result;
    logic           overflow;
    logic           zero;
    logic           sign;

    modport master (
        output in_valid, opcode, in1, in2, shamt, out_ready,
        input  in_ready, out_valid, result, overflow, zero, sign
    );

    modport slave (
        input  in_valid, opcode, in1, in2, shamt, out_ready,
        output in_ready, out_valid, result, overflow, zero, sign
    );
endinterface

// File: rtl/seq_alu_unit.sv
// Purpose  : registered ALU (add/sub/srl/sll/nand/slt/min) plus iterative unsigned multiply.
// Latency  : result valid one cycle after accept; multiply adds N shift-add cycles.
// Backpress: result held until out_ready; in_ready = IDLE | (DONE & out_ready), low during multiply.
// Ports    : clk, rst_n (async active-low), bus (seq_alu_unit_if.slave).
module seq_alu_unit #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_alu_unit_if.slave bus
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MIN  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(N - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state;
    logic [N-1:0]   result_q;
    logic           ovf_q;
    logic           out_valid_q;

    // Multiplier: multiplicand shifts left, multiplier shifts right, one bit per cycle.
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [SHW-1:0] cnt;
    logic [2*N-1:0] acc_nxt;

    logic           in_ready;
    logic           accept;
    logic [N-1:0]   alu_res;
    logic           alu_ovf;
    logic [N-1:0]   sum;
    logic [N-1:0]   diff;
    logic           lt;

    assign in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = (result_q == '0);
    assign bus.sign      = result_q[N-1];

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        sum     = bus.in1 + bus.in2;
        diff    = bus.in1 - bus.in2;
        lt      = $signed(bus.in1) < $signed(bus.in2);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.in1[N-1] == bus.in2[N-1]) && (sum[N-1] != bus.in1[N-1]);
            end
            OP_SUB: begin
                // Subtraction overflows when operand signs differ (B effectively inverted).
                alu_res = diff;
                alu_ovf = (bus.in1[N-1] != bus.in2[N-1]) && (diff[N-1] != bus.in1[N-1]);
            end
            OP_SRL:  alu_res = bus.in1 >> bus.shamt;
            OP_SLL:  alu_res = bus.in1 << bus.shamt;
            OP_NAND: alu_res = ~(bus.in1 & bus.in2);
            OP_SLT:  alu_res = {{(N-1){1'b0}}, lt};
            OP_MIN:  alu_res = lt ? bus.in1 : bus.in2;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        result_q    <= acc_nxt[N-1:0];
                        ovf_q       <= |acc_nxt[2*N-1:N];
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    // Result consumed; a same-edge accept below overrides this.
                    if ((state == DONE) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                    if (accept) begin
                        if (bus.opcode == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{N{1'b0}}, bus.in1};
                            mplier <= bus.in2;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            result_q    <= alu_res;
                            ovf_q       <= alu_ovf;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu_unit.sv
module tb_seq_alu_unit;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_alu_unit_if #(.N(N)) ifc ();

    seq_alu_unit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready=1, wait for its result, check it and let it drain.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                          input logic eo, input int elat);
        int lat;
        bit busy_ok;
        @(negedge clk);
        ifc.in_valid  = 1'b1;
        ifc.opcode    = op;
        ifc.in1       = a;
        ifc.in2       = b;
        ifc.shamt     = sh;
        ifc.out_ready = 1'b1;
        check({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!ifc.out_valid && lat < 100) begin
            if (ifc.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_result"}, 64'(ifc.result), 64'(er));
        check({tag, "_overflow"}, 64'(ifc.overflow), 64'(eo));
        check({tag, "_zero"}, 64'(ifc.zero), 64'(er == 32'd0));
        check({tag, "_sign"}, 64'(ifc.sign), 64'(er[31]));
        @(posedge clk);
    endtask

    initial begin
        int  lat;
        bit  flag;
        ifc.in_valid  = 1'b0;
        ifc.opcode    = 3'b000;
        ifc.in1       = '0;
        ifc.in2       = '0;
        ifc.shamt     = '0;
        ifc.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_result", 64'(ifc.result), 64'd0);
        check("rst_zero", 64'(ifc.zero), 64'd1);
        check("rst_sign", 64'(ifc.sign), 64'd0);
        check("rst_overflow", 64'(ifc.overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);

        // 1: add overflow, result one cycle after accept
        run_op("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, 0);

        // 2: sub then slt back-to-back, no bubble
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.opcode = 3'b001; ifc.in1 = 32'd5; ifc.in2 = 32'd5;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.opcode = 3'b101; ifc.in1 = 32'hFFFF_FFFF; ifc.in2 = 32'd1;
        check("b2b_sub_valid", 64'(ifc.out_valid), 64'd1);
        check("b2b_sub_result", 64'(ifc.result), 64'd0);
        check("b2b_sub_zero", 64'(ifc.zero), 64'd1);
        check("b2b_in_ready", 64'(ifc.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        check("b2b_slt_valid", 64'(ifc.out_valid), 64'd1);
        check("b2b_slt_result", 64'(ifc.result), 64'd1);
        check("b2b_slt_zero", 64'(ifc.zero), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_drained", 64'(ifc.out_valid), 64'd0);

        // 3: mul with product 2^32: low half 0, high half nonzero
        run_op("mul_2p32", 3'b111, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0, 1'b1, 32);

        // 4: mul 123*456, consumer stalls 5 cycles; stray inputs while busy are ignored
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.opcode = 3'b111; ifc.in1 = 32'd123; ifc.in2 = 32'd456;
        ifc.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ifc.opcode = 3'b000; ifc.in1 = 32'hDEAD; ifc.in2 = 32'hBEEF;
        lat = 0;
        flag = 1'b1;
        while (!ifc.out_valid && lat < 100) begin
            if (ifc.in_ready) flag = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("mul_hold_latency", 64'(lat), 64'd32);
        check("mul_hold_busy", 64'(flag), 64'd1);
        check("mul_hold_result", 64'(ifc.result), 64'd56088);
        check("mul_hold_overflow", 64'(ifc.overflow), 64'd0);
        flag = 1'b1;
        repeat (5) begin
            if (ifc.result !== 32'd56088 || !ifc.out_valid || ifc.in_ready) flag = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        check("mul_hold_stable", 64'(flag), 64'd1);
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        check("mul_hold_release_valid", 64'(ifc.out_valid), 64'd1);
        check("mul_hold_release_result", 64'(ifc.result), 64'd56088);
        @(posedge clk);
        @(negedge clk);
        check("mul_hold_drained", 64'(ifc.out_valid), 64'd0);
        check("mul_hold_idle_ready", 64'(ifc.in_ready), 64'd1);

        // 5: reset in the middle of a multiply
        ifc.in_valid = 1'b1; ifc.opcode = 3'b111; ifc.in1 = 32'd7; ifc.in2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("midrst_result", 64'(ifc.result), 64'd0);
        check("midrst_zero", 64'(ifc.zero), 64'd1);
        check("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midrst_no_stale", 64'(ifc.out_valid), 64'd0);
        run_op("after_rst_add", 3'b000, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 0);

        // 6 and extra directed vectors
        run_op("min", 3'b110, 32'hFFFF_FFFD, 32'd2, 5'd0, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("sll31", 3'b011, 32'd1, 32'd0, 5'd31, 32'h8000_0000, 1'b0, 0);
        run_op("nand", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 0);
        run_op("srl4", 3'b010, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 1'b0, 0);
        run_op("sub_ovf", 3'b001, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1, 0);
        run_op("slt_false", 3'b101, 32'd2, 32'hFFFF_FFFD, 5'd0, 32'h0, 1'b0, 0);
        run_op("add_neg_ovf", 3'b000, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'h0, 1'b1, 0);
        run_op("mul_max", 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h1, 1'b1, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
